mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/cond_neg_32.sv | 12 +
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the iteration count of the bit-serial datapath.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

    localparam int         ITERATIONS = 32;
    localparam logic [5:0] LAST_ITER  = 6'(ITERATIONS - 1);

endpackage

// File: rtl/cond_neg_32.sv
// 32-bit conditional two's-complement negate; cin lets two instances chain
// into a 64-bit negate (upper word gets +1 only when the lower word was zero).
module cond_neg_32 (
    input  logic        en,
    input  logic        cin,
    input  logic [31:0] a,
    output logic [31:0] y
);

    assign y = en ? (~a + {31'b0, cin}) : a;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32 shift-add or restoring
// shift-subtract steps on a shared 64-bit accumulator, then sign fix-up.
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        areset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        write_hi,
    input  logic        write_lo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        is_mul_q, is_mul_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    op_e         op_sel;
    logic        rs_neg_en;
    logic        rt_neg_en;
    logic        sign_diff;
    logic [31:0] rs_abs;
    logic [31:0] rt_abs;
    logic [31:0] hi_fix;
    logic [31:0] lo_fix;
    logic        hi_cin;
    logic [32:0] mul_sum;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] step;

    assign op_sel = op_e'(op);

    // Signed divide by zero runs unsigned so the raw dividend lands in hi.
    assign rs_neg_en = op[0] & rs_data[31] & ~((op_sel == OP_DIV) && (rt_data == 32'd0));
    assign rt_neg_en = op[0] & rt_data[31];
    assign sign_diff = rs_neg_en ^ rt_neg_en;

    cond_neg_32 u_abs_rs (.en(rs_neg_en), .cin(1'b1), .a(rs_data), .y(rs_abs));
    cond_neg_32 u_abs_rt (.en(rt_neg_en), .cin(1'b1), .a(rt_data), .y(rt_abs));

    assign hi_cin = is_mul_q ? (acc_q[31:0] == 32'd0) : 1'b1;

    cond_neg_32 u_fix_lo (.en(neg_lo_q), .cin(1'b1),   .a(acc_q[31:0]),  .y(lo_fix));
    cond_neg_32 u_fix_hi (.en(neg_hi_q), .cin(hi_cin), .a(acc_q[63:32]), .y(hi_fix));

    // One iteration: multiplier bits shift out the bottom, quotient bits in.
    assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    assign div_ge   = acc_q[63:31] >= {1'b0, opnd_q};
    assign div_diff = acc_q[62:31] - opnd_q;

    always_comb begin
        step = {acc_q[62:0], 1'b0};
        if (is_mul_q) begin
            step = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        end else if (div_ge) begin
            step = {div_diff, acc_q[30:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST_ITER) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_mul_d = is_mul_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        busy     = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d    = 6'd0;
                    acc_d    = {32'd0, rs_abs};
                    opnd_d   = rt_abs;
                    is_mul_d = ~op[1];
                    neg_lo_d = sign_diff;
                    neg_hi_d = op[1] ? rs_neg_en : sign_diff;
                end else begin
                    if (write_hi) hi_d = rs_data;
                    if (write_lo) lo_d = rs_data;
                end
            end
            ST_RUN: begin
                acc_d = step;
                cnt_d = cnt_q + 6'd1;
            end
            ST_FIN: begin
                hi_d   = hi_fix;
                lo_d   = lo_fix;
                done_d = 1'b1;
                cnt_d  = 6'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt_q    <= 6'd0;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            is_mul_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_mul_q <= is_mul_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule
